// File: rtl/uart_cmd_encoder.sv
// uart_cmd_encoder: turns pulse-generator commands into a UART byte stream, with optional inter-byte gaps.
// Optional macro UART_CMD_ENCODER_SKIP_UNCHANGED_EN: an ALL command omits configuration groups already sent unchanged.
`default_nettype none

module uart_cmd_encoder #(
  parameter int GAP_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid_i,
  input  logic [2:0]  cmd_i,
  input  logic [15:0] delay_i,
  input  logic [7:0]  width_i,
  input  logic [7:0]  num_pulses_i,
  input  logic [15:0] pulse_spacing_i,
  output logic        cmd_ready_o,
  output logic        done_o,
  output logic        err_o,
  output logic [7:0]  byte_o,
  output logic        byte_valid_o,
  input  logic        byte_ready_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [2:0] c_op_all   = 3'd5;
  localparam logic [3:0] c_idx_trig = 4'd10;
  localparam logic [7:0] c_gap_last = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_idx, r_end;
  logic [15:0] r_delay, r_spacing;
  logic [7:0]  r_width, r_num;
  logic [7:0]  r_gap;
  logic        r_done, r_err;

  logic        w_accept, w_legal, w_xfer, w_last;
  logic [3:0]  w_skip, w_skip_in;
  logic [3:0]  w_start, w_end, w_idx_nxt;
  logic [7:0]  w_byte;

  // The 11-byte ALL stream is the concatenation of groups; single opcodes address one slice of it.
  function automatic logic [3:0] f_seg_start(input logic [1:0] s);
    case (s)
      2'd0:    f_seg_start = 4'd0;
      2'd1:    f_seg_start = 4'd3;
      2'd2:    f_seg_start = 4'd5;
      default: f_seg_start = 4'd7;
    endcase
  endfunction

  function automatic logic [3:0] f_first_idx(input logic [2:0] k, input logic [3:0] skip);
    f_first_idx = c_idx_trig;
    for (int s = 3; s >= 0; s--) begin
      if ((3'(s) >= k) && !skip[s]) f_first_idx = f_seg_start(2'(s));
    end
  endfunction

  assign w_accept = cmd_valid_i && (r_state == S_IDLE);
  assign w_legal  = (cmd_i <= c_op_all);
  assign w_xfer   = (r_state == S_SEND) && byte_ready_i;
  assign w_last   = (r_idx == r_end);

`ifdef UART_CMD_ENCODER_SKIP_UNCHANGED_EN
  logic [15:0] r_sh_delay, r_sh_spacing;
  logic [7:0]  r_sh_width, r_sh_num;
  logic [3:0]  r_sh_vld;
  logic [3:0]  r_skip;

  assign w_skip    = r_skip;
  assign w_skip_in = (cmd_i != c_op_all) ? 4'b0000 :
                     {r_sh_vld[3] && (r_sh_spacing == pulse_spacing_i),
                      r_sh_vld[2] && (r_sh_num == num_pulses_i),
                      r_sh_vld[1] && (r_sh_width == width_i),
                      r_sh_vld[0] && (r_sh_delay == delay_i)};

  // A shadow becomes valid only once the final byte of its group has actually left.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh_delay   <= 16'h0000;
      r_sh_width   <= 8'h00;
      r_sh_num     <= 8'h00;
      r_sh_spacing <= 16'h0000;
      r_sh_vld     <= 4'b0000;
      r_skip       <= 4'b0000;
    end else begin
      if (w_accept && w_legal) r_skip <= w_skip_in;
      if (w_xfer) begin
        case (r_idx)
          4'd2: begin r_sh_delay   <= r_delay;   r_sh_vld[0] <= 1'b1; end
          4'd4: begin r_sh_width   <= r_width;   r_sh_vld[1] <= 1'b1; end
          4'd6: begin r_sh_num     <= r_num;     r_sh_vld[2] <= 1'b1; end
          4'd9: begin r_sh_spacing <= r_spacing; r_sh_vld[3] <= 1'b1; end
          default: ;
        endcase
      end
    end
  end
`else
  assign w_skip    = 4'b0000;
  assign w_skip_in = 4'b0000;
`endif

  always_comb begin
    w_start = 4'd0;
    w_end   = 4'd2;
    case (cmd_i)
      3'd1:    begin w_start = 4'd3;       w_end = 4'd4;       end
      3'd2:    begin w_start = 4'd5;       w_end = 4'd6;       end
      3'd3:    begin w_start = 4'd7;       w_end = 4'd9;       end
      3'd4:    begin w_start = c_idx_trig; w_end = c_idx_trig; end
      3'd5:    begin w_start = f_first_idx(3'd0, w_skip_in); w_end = c_idx_trig; end
      default: ;
    endcase
  end

  always_comb begin
    w_idx_nxt = r_idx + 4'd1;
    case (r_idx)
      4'd2:    w_idx_nxt = f_first_idx(3'd1, w_skip);
      4'd4:    w_idx_nxt = f_first_idx(3'd2, w_skip);
      4'd6:    w_idx_nxt = f_first_idx(3'd3, w_skip);
      4'd9:    w_idx_nxt = c_idx_trig;
      default: ;
    endcase
  end

  always_comb begin
    w_byte = 8'h00;
    case (r_idx)
      4'd0:    w_byte = 8'h00;
      4'd1:    w_byte = r_delay[15:8];
      4'd2:    w_byte = r_delay[7:0];
      4'd3:    w_byte = 8'h01;
      4'd4:    w_byte = r_width;
      4'd5:    w_byte = 8'h02;
      4'd6:    w_byte = r_num;
      4'd7:    w_byte = 8'h03;
      4'd8:    w_byte = r_spacing[15:8];
      4'd9:    w_byte = r_spacing[7:0];
      4'd10:   w_byte = 8'h04;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    cmd_ready_o  = 1'b0;
    byte_valid_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        if (w_accept && w_legal) w_state_nxt = S_SEND;
      end
      S_SEND: begin
        byte_valid_o = 1'b1;
        if (byte_ready_i) begin
          if (w_last)              w_state_nxt = S_IDLE;
          else if (GAP_CYCLES > 0) w_state_nxt = S_GAP;
          else                     w_state_nxt = S_SEND;
        end
      end
      S_GAP: begin
        if (r_gap == c_gap_last) w_state_nxt = S_SEND;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx     <= 4'd0;
      r_end     <= 4'd0;
      r_delay   <= 16'h0000;
      r_width   <= 8'h00;
      r_num     <= 8'h00;
      r_spacing <= 16'h0000;
      r_gap     <= 8'h00;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_accept) begin
        if (w_legal) begin
          r_delay   <= delay_i;
          r_width   <= width_i;
          r_num     <= num_pulses_i;
          r_spacing <= pulse_spacing_i;
          r_idx     <= w_start;
          r_end     <= w_end;
        end else begin
          r_err <= 1'b1;
        end
      end
      if (w_xfer) begin
        if (w_last) begin
          r_done <= 1'b1;
        end else begin
          r_idx <= w_idx_nxt;
          r_gap <= 8'h00;
        end
      end
      if (r_state == S_GAP) r_gap <= r_gap + 8'd1;
    end
  end

  assign byte_o = w_byte;
  assign done_o = r_done;
  assign err_o  = r_err;

endmodule

`default_nettype wire
